// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
// Shared definitions for the pushbutton conditioner and its consumers.
//   - btn_state_e : one-hot encoding of the per-channel debounce FSM
//   - *_DEF       : default timing constants for a 100 MHz system clock
//   - BTN_*       : channel index of each board button (the game logic uses these too)
//   - max3        : helper to size the shared per-channel counter
// ---------------------------------------------------------------------------
package button_pkg;

  localparam int N_BTN_DEF           = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 500_000;     // 5 ms at 100 MHz
  localparam int REPEAT_DELAY_DEF    = 50_000_000;  // 0.5 s
  localparam int REPEAT_PERIOD_DEF   = 20_000_000;  // 0.2 s

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

  localparam int STATE_W = 5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 5'b00001,
    ST_PRESS_DB   = 5'b00010,
    ST_HELD       = 5'b00100,
    ST_REPEAT     = 5'b01000,
    ST_RELEASE_DB = 5'b10000
  } btn_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// ---------------------------------------------------------------------------
// button_conditioner_if
// Bundle between the board buttons and the game logic.
//   btns_raw  : raw asynchronous button levels (board side drives)
//   DPBs      : debounced levels
//   SCENs     : one-cycle strobe per accepted press
//   MCENs     : one-cycle strobe on press, then at the auto-repeat rate
//   dbg_state : per-channel FSM state, one-hot, for observation only
// Handshake semantics: there is no valid/ready pair and no backpressure.
// SCENs/MCENs are single-cycle strobes that the consumer must take in the
// cycle they are high; DPBs is a level. Bits of the same bus may assert
// together and the consumer decides priority.
// Modports:
//   master : the board/stimulus side (drives btns_raw, observes outputs)
//   slave  : the conditioner (takes btns_raw, drives outputs)
// ---------------------------------------------------------------------------
interface button_conditioner_if #(
  parameter int N_BTN = 4
);

  logic [N_BTN-1:0]              btns_raw;
  logic [N_BTN-1:0]              DPBs;
  logic [N_BTN-1:0]              SCENs;
  logic [N_BTN-1:0]              MCENs;
  logic [N_BTN-1:0][4:0]         dbg_state;

  modport master (
    output btns_raw,
    input  DPBs,
    input  SCENs,
    input  MCENs,
    input  dbg_state
  );

  modport slave (
    input  btns_raw,
    output DPBs,
    output SCENs,
    output MCENs,
    output dbg_state
  );

endinterface

// File: rtl/button_debounce_channel.sv
// ---------------------------------------------------------------------------
// button_debounce_channel
// One button: 2-flop synchroniser, shared down-path counter, debounce FSM.
// Ports:
//   clk, reset  : system clock, asynchronous active-high reset
//   i_btn_raw   : raw asynchronous button level
//   o_dpb       : registered debounced level
//   o_scen      : registered one-cycle pulse per accepted press
//   o_mcen      : registered pulse on press and at the auto-repeat rate
//   o_state     : current FSM state (one-hot) for observation
// ---------------------------------------------------------------------------
module button_debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_btn_raw,
  output logic               o_dpb,
  output logic               o_scen,
  output logic               o_mcen,
  output logic [STATE_W-1:0] o_state
);

  // One counter serves all timed states, so it is sized for the longest.
  localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [1:0]       r_sync;
  btn_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dpb;
  logic             r_scen;
  logic             r_mcen;

  logic             w_s;
  btn_state_e       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_dpb_nxt;
  logic             w_scen_nxt;
  logic             w_mcen_nxt;

  assign w_s = r_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync  <= 2'b00;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_dpb   <= 1'b0;
      r_scen  <= 1'b0;
      r_mcen  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn_raw};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dpb   <= w_dpb_nxt;
      r_scen  <= w_scen_nxt;
      r_mcen  <= w_mcen_nxt;
    end
  end

  // Outputs are computed alongside the transition and registered with the
  // state, so a press strobe appears in the cycle HELD is entered.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_dpb_nxt   = r_dpb;
    w_scen_nxt  = 1'b0;
    w_mcen_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_s) w_state_nxt = ST_PRESS_DB;
      end
      ST_PRESS_DB: begin
        if (!w_s) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
          w_dpb_nxt   = 1'b1;
          w_scen_nxt  = 1'b1;
          w_mcen_nxt  = 1'b1;
        end
      end
      ST_HELD: begin
        if (!w_s) begin
          w_state_nxt = ST_RELEASE_DB;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DLY_LAST) begin
          w_state_nxt = ST_REPEAT;
          w_cnt_nxt   = '0;
          w_mcen_nxt  = 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!w_s) begin
          w_state_nxt = ST_RELEASE_DB;
          w_cnt_nxt   = '0;
        end else if (r_cnt == PER_LAST) begin
          w_cnt_nxt   = '0;
          w_mcen_nxt  = 1'b1;
        end
      end
      ST_RELEASE_DB: begin
        // A bounce back to 1 is still the same press: return to HELD
        // silently and restart the repeat delay.
        if (w_s) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_dpb_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_dpb_nxt   = 1'b0;
      end
    endcase
  end

  assign o_dpb   = r_dpb;
  assign o_scen  = r_scen;
  assign o_mcen  = r_mcen;
  assign o_state = r_state;

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// Replicates one debounce channel per board button and concatenates the
// results onto the interface bus.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : slave side of button_conditioner_if (btns_raw in;
//                DPBs/SCENs/MCENs/dbg_state out)
// ---------------------------------------------------------------------------
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input logic                 clk,
  input logic                 reset,
  button_conditioner_if.slave bus
);

  logic [N_BTN-1:0]              w_dpb;
  logic [N_BTN-1:0]              w_scen;
  logic [N_BTN-1:0]              w_mcen;
  logic [N_BTN-1:0][STATE_W-1:0] w_state;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    button_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .i_btn_raw (bus.btns_raw[g]),
      .o_dpb     (w_dpb[g]),
      .o_scen    (w_scen[g]),
      .o_mcen    (w_mcen[g]),
      .o_state   (w_state[g])
    );
  end

  assign bus.DPBs      = w_dpb;
  assign bus.SCENs     = w_scen;
  assign bus.MCENs     = w_mcen;
  assign bus.dbg_state = w_state;

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
// Directed stimulus for the button conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=5. Each step drives inputs for the coming
// clock edge k (edge 0 is the first edge that sees the new input) and
// queues the hand-derived {DPBs,SCENs,MCENs} expected after that edge;
// a monitor pops and compares one entry per edge.
// ---------------------------------------------------------------------------
module tb_button_conditioner;
  import button_pkg::*;

  localparam int DB  = 4;
  localparam int DLY = 10;
  localparam int PER = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  button_conditioner_if #(.N_BTN(4)) bus ();

  button_conditioner #(
    .N_BTN           (4),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (DLY),
    .REPEAT_PERIOD   (PER)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [11:0] mon_e;
  logic [11:0] mon_a;
  string       mon_nm;

  function automatic logic [11:0] mk(input logic [3:0] d, input logic [3:0] s,
                                     input logic [3:0] m);
    return {d, s, m};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rst_v, input logic [3:0] raw,
                      input logic [11:0] exp, input string nm);
    @(negedge clk);
    reset        = rst_v;
    bus.btns_raw = raw;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e  = exp_q.pop_front();
        mon_nm = name_q.pop_front();
        mon_a  = {bus.DPBs, bus.SCENs, bus.MCENs};
        n_cmp++;
        if (mon_a !== mon_e) begin
          n_bad++;
          $display("FAIL %s @%0t: got dpb/scen/mcen=%b_%b_%b expected %b_%b_%b",
                   mon_nm, $time, mon_a[11:8], mon_a[7:4], mon_a[3:0],
                   mon_e[11:8], mon_e[7:4], mon_e[3:0]);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, %0d compared so far", n_cmp);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  logic [3:0] e_d;
  logic [3:0] e_s;
  logic [3:0] e_m;
  logic [3:0] raw_v;
  logic       rst_v;
  logic [5:0] bpat;

  initial begin
    reset        = 1'b1;
    bus.btns_raw = 4'b0000;
    #12;
    check("reset_outputs", 32'({bus.DPBs, bus.SCENs, bus.MCENs}), 32'd0);
    check("reset_state", 32'(bus.dbg_state), 32'({4{ST_IDLE}}));
    step(1'b1, 4'b0000, 12'd0, "in_reset");
    step(1'b0, 4'b0000, 12'd0, "idle");
    step(1'b0, 4'b0000, 12'd0, "idle");

    // Clean press on UP: held edges 0..11, released before edge 12.
    // Strobes after edge 6 only; DPB low after edge 12+6=18.
    for (int k = 0; k <= 22; k++) begin
      raw_v = (k < 12) ? 4'b0001 : 4'b0000;
      e_d   = (k >= 6 && k <= 17) ? 4'b0001 : 4'b0000;
      e_s   = (k == 6) ? 4'b0001 : 4'b0000;
      step(1'b0, raw_v, mk(e_d, e_s, e_s), (k < 12) ? "clean_press" : "clean_release");
    end

    // Bounce on DOWN: 1,1,0,1,1,0 then 0 -- never 5 stable samples.
    bpat = 6'b011011;
    for (int k = 0; k <= 15; k++) begin
      raw_v = (k < 6) ? {2'b00, bpat[k], 1'b0} : 4'b0000;
      step(1'b0, raw_v, 12'd0, "bounce_reject");
    end

    // Auto-repeat on RIGHT: held edges 0..39. The FSM still sees the
    // button at edge 41 (2-flop delay), so the REPEAT pulse due at 41
    // also fires; release detected at edge 42, DPB low after edge 46.
    for (int k = 0; k <= 50; k++) begin
      raw_v = (k < 40) ? 4'b1000 : 4'b0000;
      e_d   = (k >= 6 && k <= 45) ? 4'b1000 : 4'b0000;
      e_s   = (k == 6) ? 4'b1000 : 4'b0000;
      e_m   = (k == 6 || k == 16 || k == 21 || k == 26 || k == 31 ||
               k == 36 || k == 41) ? 4'b1000 : 4'b0000;
      step(1'b0, raw_v, mk(e_d, e_s, e_m), "auto_repeat");
    end

    // Release bounce on RIGHT: REPEAT from edge 16; input low for edges
    // 22,23; FSM is in RELEASE_DB at edges 24,25 and back in HELD at 26.
    // Next MCEN 10 cycles later at 36. Released before edge 38 -> seen at
    // edge 40 -> DPB low after edge 44.
    for (int k = 0; k <= 48; k++) begin
      raw_v = ((k < 22) || (k >= 24 && k < 38)) ? 4'b1000 : 4'b0000;
      e_d   = (k >= 6 && k <= 43) ? 4'b1000 : 4'b0000;
      e_s   = (k == 6) ? 4'b1000 : 4'b0000;
      e_m   = (k == 6 || k == 16 || k == 21 || k == 36) ? 4'b1000 : 4'b0000;
      step(1'b0, raw_v, mk(e_d, e_s, e_m), (k < 22) ? "rel_bounce_hold" : "rel_bounce_after");
    end

    // UP and LEFT together; reset asserted mid-REPEAT before edge 19,
    // released before edge 21 with buttons still held: re-debounce gives
    // SCEN after edge 21+6=27. Released before edge 30 -> DPB low after 36.
    for (int k = 0; k <= 40; k++) begin
      rst_v = (k == 19 || k == 20);
      raw_v = (k < 30) ? 4'b0101 : 4'b0000;
      e_d   = ((k >= 6 && k <= 18) || (k >= 27 && k <= 35)) ? 4'b0101 : 4'b0000;
      e_s   = (k == 6 || k == 27) ? 4'b0101 : 4'b0000;
      e_m   = (k == 6 || k == 16 || k == 27) ? 4'b0101 : 4'b0000;
      if (k == 19)
        check("pre_reset_dpb", 32'(bus.DPBs), 32'h5);
      step(rst_v, raw_v, mk(e_d, e_s, e_m), (k < 19) ? "dual_press" : "reset_repress");
      if (k == 19) begin
        #1;
        check("async_reset_outputs", 32'({bus.DPBs, bus.SCENs, bus.MCENs}), 32'd0);
        check("async_reset_state", 32'(bus.dbg_state), 32'({4{ST_IDLE}}));
      end
    end

    step(1'b0, 4'b0000, 12'd0, "tail_idle");
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the four raw board pushbuttons (up, down, left, right) into clean, registered control signals for the game logic. It synchronises each button and debounces it with a per-channel state machine. For each button it produces a debounced level (`DPBs`), a single-clock enable on each press (`SCENs`), and an auto-repeating enable while the button is held (`MCENs`). It sits directly upstream of the game-logic block, which consumes `DPBs`/`SCENs` for player movement.

## Interface
- `N_BTN`, 4: number of button channels; bit 0 up, 1 down, 2 left, 3 right.
- `DEBOUNCE_CYCLES`, 500_000: cycles the synchronised input must be stable to accept a press or release (5 ms at 100 MHz); ≥2.
- `REPEAT_DELAY`, 50_000_000: cycles from accepted press to first repeat `MCEN`; ≥2.
- `REPEAT_PERIOD`, 20_000_000: cycles between subsequent repeat `MCEN`s; ≥2.
- `clk` in 1: system clock; one clock domain.
- `reset` in 1: reset, asynchronous, active-high.
- `btns_raw` in N_BTN: raw, unsynchronised, active-high button inputs.
- `DPBs` out N_BTN: debounced button level.
- `SCENs` out N_BTN: one-cycle pulse per accepted press.
- `MCENs` out N_BTN: one-cycle pulse on press, then at auto-repeat rate while held.

## Operation
- Per channel: a 2-flop synchroniser feeds the FSM. The counter width is `$clog2` of the largest of the three parameters. All outputs are registered.
- FSM states and transitions, where `s` is the synchroniser output:
  - IDLE: `s`=1 → PRESS_DB, with cnt=0.
  - PRESS_DB: `s`=0 → IDLE.
    - cnt==DEBOUNCE_CYCLES-1 → HELD: cnt=0, `DPBs`=1, `SCENs`=1 for one cycle, `MCENs`=1 for one cycle.
    - Otherwise cnt+1.
  - HELD: `s`=0 → RELEASE_DB, with cnt=0.
    - cnt==REPEAT_DELAY-1 → REPEAT: cnt=0, `MCENs` pulse.
    - Otherwise cnt+1.
  - REPEAT: `s`=0 → RELEASE_DB, with cnt=0.
    - cnt==REPEAT_PERIOD-1: `MCENs` pulse, cnt=0.
    - Otherwise cnt+1.
  - RELEASE_DB: `s`=1 → HELD, with cnt=0, no `SCENs`/`MCENs` pulse; a bounce on release restarts the repeat delay.
    - cnt==DEBOUNCE_CYCLES-1 → IDLE with `DPBs`=0.
    - Otherwise cnt+1.
- `DPBs` stays 1 from entry to HELD until entry to IDLE from RELEASE_DB.
- Channels are fully independent. Several `SCENs`/`MCENs` bits may assert in the same cycle; priority is the consumer's responsibility.
- An input pulse shorter than DEBOUNCE_CYCLES stable cycles produces no output.

## Timing
- Reset values: `DPBs`=0, `SCENs`=0, `MCENs`=0, all FSMs IDLE, counters 0, synchroniser flops 0. Reset takes effect immediately and asynchronously.
- Reset asserted mid-press clears outputs at once. After release of reset, a still-held button must be re-debounced from IDLE and then produces a fresh `SCENs`.
- Press latency: `btns_raw` high before edge 0 gives `SCENs`/`MCENs` high in the cycle following edge DEBOUNCE_CYCLES+2, for exactly one cycle.
- First repeat `MCENs` comes REPEAT_DELAY cycles after the press `MCENs`. Later repeats are spaced REPEAT_PERIOD cycles apart.
- Release latency: `btns_raw` low before edge r gives `DPBs` low after edge r+DEBOUNCE_CYCLES+2.
- `SCENs` never asserts twice without an intervening return to IDLE.

## Structure
- Shared package `button_pkg` holds:
  - FSM state encoding (one-hot, 5 states);
  - default timing constants;
  - the channel-index constants BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3, also used by the game logic.
- Sub-module `button_debounce_channel`, one instance per bit via generate, contains:
  - the synchroniser;
  - the counter;
  - the FSM.
- The top level only replicates `button_debounce_channel` and concatenates its outputs.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
- Clean press: `btns_raw[0]` rises before edge 0 and is held 12 cycles → `SCENs[0]`/`MCENs[0]` high only in the cycle after edge 6, and `DPBs[0]`=1 from edge 6.
  - Then release → `DPBs[0]`=0 exactly 6 cycles after the release edge.
- Bounce rejection: `btns_raw[1]` toggles 1,1,0,1,1,0 per cycle, then stays 0 → no `DPBs`/`SCENs`/`MCENs` activity.
- Auto-repeat: hold `btns_raw[3]` for 40 cycles → `MCENs[3]` pulses at edges 6, 16, 21, 26, 31, 36 relative to the press, with a single `SCENs[3]` at edge 6.
- Release bounce: while in REPEAT, drop the input for 2 cycles, then hold high → `DPBs` stays 1, no new `SCENs`, and the next `MCENs` comes 10 cycles after the input returns to 1 in HELD.
- Reset mid-press plus simultaneity: press bits 0 and 2 on the same edge → both `SCENs` assert in the same cycle.
  - Assert `reset` asynchronously mid-REPEAT → all outputs 0 within the same cycle.
  - Deassert `reset` with buttons held → new `SCENs` DEBOUNCE_CYCLES+2 cycles later.
